uart_rx_core: RTL and testbench
===============================

Name: uart_rx_core

Overview:
Oversampling UART receiver. Recovers 7- or 8-bit characters from a serial line and flags parity and framing problems. Sits behind the host-link UART: receives command characters such as "stop", "rd 0000" and "wr 4002 FE", and hands each byte to the command parser as a one-cycle strobe. CLK is the oversampled bit clock (OVER_SAMPLING ticks per bit), produced upstream by a clock divider.

Parameters:
OVER_SAMPLING, 8, CLK ticks per bit period; even, >=4.

Ports:
CLK  in  1  oversampling clock; all logic on rising edge
RST_N  in  1  reset; one clock; reset is synchronous and active-high (RST_N=1 resets)
iSEVEN_BIT  in  1  0 = 8 data bits, 1 = 7 data bits
iPARITY_EN  in  1  1 = parity bit follows the data bits
iODD_PARITY  in  1  0 = even parity, 1 = odd parity
iSTOP_BIT  in  1  0 = 1 stop bit, 1 = 2 stop bits
iUART_RX  in  1  asynchronous serial input; idle high
oRETRY  out  1  one-cycle pulse on false start or framing error
oPARITY_ERROR  out  1  one-cycle pulse, coincident with oDE, when parity mismatches
oDE  out  1  one-cycle strobe: oDATA holds a new character
oDATA  out  8  received character, LSB first on the line; bit7 = 0 in 7-bit mode

Behaviour:
- Reset: all outputs 0, state IDLE, synchronizer flops preset to 1 (idle line).
- iUART_RX passes through a 2-flop synchronizer; all sampling uses the synchronized value (2-cycle input latency).
- Config inputs are latched at start detection. Changes mid-frame do not affect the current frame.
- States and transitions:
  - IDLE: stay until a falling edge (sync 1->0); then clear the tick counter and go to START.
  - START: at tick OVER_SAMPLING/2-1 (mid-bit):
    - line high -> pulse oRETRY, go to IDLE;
    - line low -> go to DATA, reset tick counter.
  - DATA: sample every OVER_SAMPLING ticks at mid-bit and shift into a data register LSB first. After 7 or 8 samples, go to PARITY if enabled, else STOP.
  - PARITY: sample one bit. Error = (XOR of data bits ^ parity bit) != iODD_PARITY.
  - STOP: sample 1 or 2 stop bits.
    - Any sampled stop bit low -> pulse oRETRY, drop the character (no oDE), go to IDLE. The line must return high before the next start is accepted.
    - All stop bits high -> on the next clock, load oDATA, pulse oDE and oPARITY_ERROR (if error), go to IDLE.
- Latency: oDE asserts 1 clock after the mid-sample of the last stop bit. oDATA holds its value until the next oDE.
- Back-to-back frames: a new falling edge is accepted in IDLE immediately after the stop-bit sample. The second half of the stop bit does not need to be waited out.
- Break condition (line held low): exactly one oRETRY per framing error. IDLE re-arms only after the line returns high.
- Reset mid-frame: abort immediately. No oDE or oRETRY is emitted for the partial frame.
- oRETRY and oDE are never asserted in the same cycle.

Optional Feature:
UART_RX_MAJORITY_EN
- Defined: each bit (start, data, parity, stop) is a 2-of-3 majority of samples at ticks OVER_SAMPLING/2-2, /2-1 and /2. The decision is made at tick /2, so oDE latency grows by 1 clock.
- Undefined: single sample at tick OVER_SAMPLING/2-1.

Decomposition:
- Package uart_pkg:
  - state enum (IDLE, START, DATA, PARITY, STOP);
  - DATA_WIDTH=8 constant;
  - tick-counter width function clog2(OVER_SAMPLING).
- One sub-module: uart_rx_sync (2-flop synchronizer with preset-to-1 on reset).

Test Plan:
- 7N1, send 's' (0x73) then 't' (0x74) back-to-back: two oDE strobes, oDATA=0x73 then 0x74, oDATA[7]=0, oRETRY and oPARITY_ERROR never set.
- 8E1, send 0xA5 with parity 0: oDE with oDATA=0xA5 and oPARITY_ERROR=0. Send 0xA5 with parity 1: oDE with oPARITY_ERROR=1 in the same cycle.
- 8O2, send 0x3C with the second stop bit low: oRETRY pulse, no oDE, oDATA keeps its previous value.
- Glitch of 2 CLK low on an idle line (OVER_SAMPLING=8): one oRETRY pulse, no oDE; a following valid 0x0A frame is received correctly.
- Assert RST_N for one cycle during data bit 3 of a frame: all outputs 0, no strobes. The next full frame 0x55 is received normally.
- With UART_RX_MAJORITY_EN, a 1-tick inverted glitch at mid-bit of data bit 0 of 0x01: oDATA=0x01 is still received.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared types and constants for the oversampling UART receiver.
// Contents: receiver state enum, character width, and a ceil-log2 helper
// used to size the tick and bit-index counters.
package uart_pkg;

   localparam int unsigned DATA_WIDTH = 8;

   typedef enum logic [2:0] {
      IDLE,
      START,
      DATA,
      PARITY,
      STOP
   } state_t;

   // Bits needed to count 0..value-1 (at least 1).
   function automatic int unsigned clog2(input int unsigned value);
      int unsigned r;
      int unsigned v;
      r = 0;
      v = value - 1;
      while (v != 0) begin
         r = r + 1;
         v = v >> 1;
      end
      return (r == 0) ? 1 : r;
   endfunction

endpackage

// File: rtl/uart_rx_sync.sv
// Two-flop synchronizer for the asynchronous serial line.
// Flops preset to 1 on reset so an idle line is seen after reset.
// Ports:
//   CLK     in  clock
//   RST_N   in  synchronous active-high reset
//   i_async in  asynchronous input
//   o_sync  out synchronized output (2-cycle latency)
module uart_rx_sync (
   input  logic CLK,
   input  logic RST_N,
   input  logic i_async,
   output logic o_sync
);

   logic [1:0] r_meta;

   always_ff @(posedge CLK) begin
      if (RST_N) begin
         r_meta <= 2'b11;
      end else begin
         r_meta <= {r_meta[0], i_async};
      end
   end

   assign o_sync = r_meta[1];

endmodule

// File: rtl/uart_rx_core.sv
// Oversampling UART receiver: 7/8 data bits, optional even/odd parity,
// 1 or 2 stop bits. Delivers each character as a one-cycle oDE strobe.
// Optional build macro: UART_RX_MAJORITY_EN (2-of-3 majority voting per bit,
// decision one tick later than the single-sample default).
// Ports:
//   CLK           in  oversampling clock (OVER_SAMPLING ticks per bit)
//   RST_N         in  synchronous active-high reset
//   iSEVEN_BIT    in  1 = 7 data bits, 0 = 8
//   iPARITY_EN    in  1 = parity bit present
//   iODD_PARITY   in  1 = odd parity, 0 = even
//   iSTOP_BIT     in  1 = 2 stop bits, 0 = 1
//   iUART_RX      in  asynchronous serial input, idle high
//   oRETRY        out pulse on false start or framing error
//   oPARITY_ERROR out pulse with oDE when parity mismatches
//   oDE           out one-cycle strobe, oDATA holds a new character
//   oDATA         out received character (bit7 = 0 in 7-bit mode)
module uart_rx_core
   import uart_pkg::*;
#(
   parameter int unsigned OVER_SAMPLING = 8
) (
   input  logic                  CLK,
   input  logic                  RST_N,
   input  logic                  iSEVEN_BIT,
   input  logic                  iPARITY_EN,
   input  logic                  iODD_PARITY,
   input  logic                  iSTOP_BIT,
   input  logic                  iUART_RX,
   output logic                  oRETRY,
   output logic                  oPARITY_ERROR,
   output logic                  oDE,
   output logic [DATA_WIDTH-1:0] oDATA
);

   localparam int unsigned CNT_W = clog2(OVER_SAMPLING);
   localparam int unsigned IDX_W = clog2(DATA_WIDTH);
   localparam int unsigned HALF  = OVER_SAMPLING / 2;
`ifdef UART_RX_MAJORITY_EN
   localparam int unsigned START_TICK = HALF;
`else
   localparam int unsigned START_TICK = HALF - 1;
`endif

   state_t                r_state;
   state_t                w_next;
   logic [CNT_W-1:0]      r_cnt;
   logic [IDX_W-1:0]      r_idx;
   logic                  r_stop_idx;
   logic [DATA_WIDTH-1:0] r_shift;
   logic                  r_par_err;
   logic                  r_cfg_seven;
   logic                  r_cfg_par;
   logic                  r_cfg_odd;
   logic                  r_cfg_two;
   logic                  r_rx_prev;
   logic                  w_rx;
   logic                  w_bit;
   logic                  w_fall;
   logic                  w_tick;
   logic                  w_last_data;
   logic                  w_retry;
   logic                  w_de;
   logic                  w_sample_data;
   logic                  w_sample_par;
   logic                  w_sample_stop;

   uart_rx_sync u_sync (
      .CLK     (CLK),
      .RST_N   (RST_N),
      .i_async (iUART_RX),
      .o_sync  (w_rx)
   );

   // Bit decision: majority of the last three synchronized samples, or the current one.
`ifdef UART_RX_MAJORITY_EN
   logic r_rx_prev2;
   assign w_bit = (r_rx_prev2 & r_rx_prev) | (r_rx_prev2 & w_rx) | (r_rx_prev & w_rx);
`else
   assign w_bit = w_rx;
`endif

   assign w_fall      = r_rx_prev & ~w_rx;
   // START decides near mid-bit; later states decide one full bit after the previous decision.
   assign w_tick      = (r_state == START) ? (r_cnt == CNT_W'(START_TICK))
                                           : (r_cnt == CNT_W'(OVER_SAMPLING - 1));
   assign w_last_data = (r_idx == (r_cfg_seven ? IDX_W'(DATA_WIDTH - 2) : IDX_W'(DATA_WIDTH - 1)));

   // State register.
   always_ff @(posedge CLK) begin
      if (RST_N) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_next;
      end
   end

   // Next-state logic.
   always_comb begin
      w_next = r_state;
      case (r_state)
         IDLE:   if (w_fall) w_next = START;
         START:  if (w_tick) w_next = w_bit ? IDLE : DATA;
         DATA:   if (w_tick && w_last_data) w_next = r_cfg_par ? PARITY : STOP;
         PARITY: if (w_tick) w_next = STOP;
         STOP: begin
            if (w_tick) begin
               if (!w_bit || !r_cfg_two || r_stop_idx) w_next = IDLE;
            end
         end
         default: w_next = IDLE;
      endcase
   end

   // Output / datapath decode.
   always_comb begin
      w_retry       = 1'b0;
      w_de          = 1'b0;
      w_sample_data = 1'b0;
      w_sample_par  = 1'b0;
      w_sample_stop = 1'b0;
      case (r_state)
         START:  w_retry       = w_tick & w_bit;
         DATA:   w_sample_data = w_tick;
         PARITY: w_sample_par  = w_tick;
         STOP: begin
            w_sample_stop = w_tick;
            w_retry       = w_tick & ~w_bit;
            w_de          = w_tick & w_bit & (~r_cfg_two | r_stop_idx);
         end
         default: ;
      endcase
   end

   // Datapath and registered outputs.
   always_ff @(posedge CLK) begin
      if (RST_N) begin
         r_cnt         <= '0;
         r_idx         <= '0;
         r_stop_idx    <= 1'b0;
         r_shift       <= '0;
         r_par_err     <= 1'b0;
         r_cfg_seven   <= 1'b0;
         r_cfg_par     <= 1'b0;
         r_cfg_odd     <= 1'b0;
         r_cfg_two     <= 1'b0;
         r_rx_prev     <= 1'b1;
`ifdef UART_RX_MAJORITY_EN
         r_rx_prev2    <= 1'b1;
`endif
         oRETRY        <= 1'b0;
         oPARITY_ERROR <= 1'b0;
         oDE           <= 1'b0;
         oDATA         <= '0;
      end else begin
         r_rx_prev     <= w_rx;
`ifdef UART_RX_MAJORITY_EN
         r_rx_prev2    <= r_rx_prev;
`endif
         oRETRY        <= w_retry;
         oDE           <= w_de;
         oPARITY_ERROR <= w_de & r_par_err;
         if (w_de) oDATA <= r_shift;

         if (r_state == IDLE) begin
            r_cnt <= '0;
            // Frame configuration is frozen at start detection.
            if (w_fall) begin
               r_cfg_seven <= iSEVEN_BIT;
               r_cfg_par   <= iPARITY_EN;
               r_cfg_odd   <= iODD_PARITY;
               r_cfg_two   <= iSTOP_BIT;
               r_idx       <= '0;
               r_stop_idx  <= 1'b0;
               r_shift     <= '0;
               r_par_err   <= 1'b0;
            end
         end else begin
            r_cnt <= w_tick ? '0 : r_cnt + CNT_W'(1);
            if (w_sample_data) begin
               r_shift[r_idx] <= w_bit;
               r_idx          <= r_idx + IDX_W'(1);
            end
            // Unused bit7 stays 0 in 7-bit mode, so it does not disturb the XOR.
            if (w_sample_par) r_par_err <= ((^r_shift) ^ w_bit) != r_cfg_odd;
            if (w_sample_stop) r_stop_idx <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_uart_rx_core.sv
// Scoreboard bench for uart_rx_core: the stimulus side serialises frames and
// queues the expected result; a monitor pops and compares on every strobe.
module tb_uart_rx_core;

   localparam int OS = 8;

   logic       CLK = 1'b0;
   logic       RST_N;
   logic       iSEVEN_BIT;
   logic       iPARITY_EN;
   logic       iODD_PARITY;
   logic       iSTOP_BIT;
   logic       iUART_RX;
   logic       oRETRY;
   logic       oPARITY_ERROR;
   logic       oDE;
   logic [7:0] oDATA;

   typedef struct {
      logic       is_de;
      logic [7:0] data;
      logic       perr;
   } exp_t;

   exp_t       q[$];
   int         total = 0;
   int         bad = 0;
   logic [7:0] exp_last = 8'h00;
   logic       mon_en = 1'b0;

   always #5 CLK = ~CLK;

   uart_rx_core #(.OVER_SAMPLING(OS)) dut (
      .CLK           (CLK),
      .RST_N         (RST_N),
      .iSEVEN_BIT    (iSEVEN_BIT),
      .iPARITY_EN    (iPARITY_EN),
      .iODD_PARITY   (iODD_PARITY),
      .iSTOP_BIT     (iSTOP_BIT),
      .iUART_RX      (iUART_RX),
      .oRETRY        (oRETRY),
      .oPARITY_ERROR (oPARITY_ERROR),
      .oDE           (oDE),
      .oDATA         (oDATA)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Monitor: compares every strobe against the head of the expected queue.
   initial begin
      exp_t e;
      forever begin
         @(negedge CLK);
         if (mon_en) begin
            if (oPARITY_ERROR && !oDE) chk("perr_without_de", {31'd0, oPARITY_ERROR}, 32'd0);
            if (oDE || oRETRY) begin
               chk("de_retry_exclusive", {31'd0, oDE & oRETRY}, 32'd0);
               if (q.size() == 0) begin
                  chk("unexpected_strobe", {30'd0, oDE, oRETRY}, 32'd0);
               end else begin
                  e = q.pop_front();
                  chk("strobe_kind_de", {31'd0, oDE}, {31'd0, e.is_de});
                  if (e.is_de) begin
                     chk("data", {24'd0, oDATA}, {24'd0, e.data});
                     chk("parity_error", {31'd0, oPARITY_ERROR}, {31'd0, e.perr});
                     exp_last = e.data;
                  end else begin
                     chk("data_hold_on_retry", {24'd0, oDATA}, {24'd0, exp_last});
                  end
               end
            end
         end
      end
   end

   task automatic drive_bit(input logic b);
      iUART_RX = b;
      repeat (OS) @(negedge CLK);
   endtask

   // Serialise one frame and queue what the receiver must report for it.
   task automatic send(input logic [7:0] d, input logic seven, input logic par_en,
                       input logic odd, input logic two, input logic par_flip,
                       input logic [1:0] stop_bad, input int gap_bits,
                       input logic scramble, input logic glitch0);
      exp_t       e;
      logic [7:0] dm;
      logic       p;
      logic [1:0] sb;
      int         nbits;
      nbits = seven ? 7 : 8;
      dm    = seven ? (d & 8'h7F) : d;
      p     = (^dm) ^ odd ^ par_flip;
      sb    = two ? stop_bad : {1'b0, stop_bad[0]};
      if (sb != 2'b00) begin
         e.is_de = 1'b0; e.data = 8'h00; e.perr = 1'b0;
      end else begin
         e.is_de = 1'b1; e.data = dm; e.perr = (((^dm) ^ p) != odd);
      end
      q.push_back(e);
      iSEVEN_BIT = seven; iPARITY_EN = par_en; iODD_PARITY = odd; iSTOP_BIT = two;
      drive_bit(1'b0);
      if (scramble) begin
         iSEVEN_BIT  = 1'($urandom_range(0, 1));
         iPARITY_EN  = 1'($urandom_range(0, 1));
         iODD_PARITY = 1'($urandom_range(0, 1));
         iSTOP_BIT   = 1'($urandom_range(0, 1));
      end
      for (int i = 0; i < nbits; i++) begin
         if (i == 0 && glitch0) begin
            iUART_RX = dm[0];
            repeat (OS / 2) @(negedge CLK);
            iUART_RX = ~dm[0];
            @(negedge CLK);
            iUART_RX = dm[0];
            repeat (OS / 2 - 1) @(negedge CLK);
         end else begin
            drive_bit(dm[i]);
         end
      end
      if (par_en) drive_bit(p);
      drive_bit(~sb[0]);
      if (two) drive_bit(~sb[1]);
      for (int i = 0; i < gap_bits; i++) drive_bit(1'b1);
   endtask

   task automatic wait_drain(input string name);
      for (int i = 0; i < 40 * OS && q.size() != 0; i++) @(negedge CLK);
      chk(name, q.size(), 32'd0);
   endtask

   initial begin
      exp_t e;
      logic [7:0] d;
      logic       sv, pe, od, tw, fl;
      logic [1:0] sbad;
      int         gap;

      RST_N = 1'b1; iUART_RX = 1'b1;
      iSEVEN_BIT = 1'b0; iPARITY_EN = 1'b0; iODD_PARITY = 1'b0; iSTOP_BIT = 1'b0;
      repeat (3) @(negedge CLK);
      RST_N = 1'b0;
      @(negedge CLK);
      chk("reset_oDE", {31'd0, oDE}, 32'd0);
      chk("reset_oRETRY", {31'd0, oRETRY}, 32'd0);
      chk("reset_oPARITY_ERROR", {31'd0, oPARITY_ERROR}, 32'd0);
      chk("reset_oDATA", {24'd0, oDATA}, 32'd0);
      repeat (2 * OS) @(negedge CLK);
      mon_en = 1'b1;

      // 7N1 back-to-back 's','t'
      send(8'h73, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 0, 1'b0, 1'b0);
      send(8'h74, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1, 1'b0, 1'b0);
      // 8E1 good and bad parity
      send(8'hA5, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 1, 1'b0, 1'b0);
      send(8'hA5, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 2'b00, 1, 1'b0, 1'b0);
      // 8O2 with second stop bit low
      send(8'h3C, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 2'b10, 2, 1'b0, 1'b0);

      // 2-tick glitch on idle line -> one false-start retry
      e.is_de = 1'b0; e.data = 8'h00; e.perr = 1'b0;
      q.push_back(e);
      iUART_RX = 1'b0;
      repeat (2) @(negedge CLK);
      iUART_RX = 1'b1;
      repeat (2 * OS) @(negedge CLK);
      send(8'h0A, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1, 1'b0, 1'b0);
      wait_drain("drain_before_reset");

      // Reset in the middle of data bit 3 of 0x55
      iSEVEN_BIT = 1'b0; iPARITY_EN = 1'b0; iSTOP_BIT = 1'b0;
      drive_bit(1'b0);
      drive_bit(1'b1); drive_bit(1'b0); drive_bit(1'b1);
      iUART_RX = 1'b0;
      repeat (OS / 2) @(negedge CLK);
      RST_N = 1'b1;
      @(negedge CLK);
      RST_N = 1'b0; iUART_RX = 1'b1; exp_last = 8'h00;
      chk("midreset_oDE", {31'd0, oDE}, 32'd0);
      chk("midreset_oRETRY", {31'd0, oRETRY}, 32'd0);
      chk("midreset_oDATA", {24'd0, oDATA}, 32'd0);
      repeat (3 * OS) @(negedge CLK);
      send(8'h55, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1, 1'b0, 1'b0);

`ifdef UART_RX_MAJORITY_EN
      send(8'h01, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1, 1'b0, 1'b1);
`endif

      // Randomised frames with mid-frame config scrambling
      for (int n = 0; n < 40; n++) begin
         d    = 8'($urandom);
         sv   = 1'($urandom_range(0, 1));
         pe   = 1'($urandom_range(0, 1));
         od   = 1'($urandom_range(0, 1));
         tw   = 1'($urandom_range(0, 1));
         fl   = pe & 1'($urandom_range(0, 1));
         sbad = ($urandom_range(0, 7) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
         gap  = (sbad != 2'b00) ? int'($urandom_range(1, 2)) : int'($urandom_range(0, 2));
         send(d, sv, pe, od, tw, fl, sbad, gap, 1'b1, 1'b0);
      end

      wait_drain("final_drain");
      repeat (4) @(negedge CLK);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
